controle_vedacao: RTL and testbench
===================================

Name: controle_vedacao

Overview:
- Sealing-station controller on the bottling line; initiator side of the cork-consumption interface.
- Detects a bottle at the sealing position and checks cork availability and refill status from the cork counter.
- Drives the sealing actuator for a fixed time, then sends the one-cycle "sealing complete" pulse that the counter decrements on.
- Releases the bottle to the conveyor and keeps a saturating count of sealed bottles for display.

Parameters:
TEMPO_VEDACAO, 26'd25000000, actuator-on time in clk cycles (0.5 s at 50 MHz); legal range ≥ 1
MAX_VEDADAS, 14'd9999, saturation value of total_vedadas

Ports:
clk  input  1  50 MHz system clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
enable  input  1  line running; new cycles start only while high
garrafa_posicionada  input  1  bottle-at-sealer sensor, level, already synchronised
rolha_disponivel  input  1  counter holds ≥ 1 cork (inverse of empty alarm)
dispensador_ativo  input  1  automatic refill in progress; no sealing may start while high
atuador_vedacao  output  1  sealing actuator drive
vedacao_concluida  output  1  one-cycle pulse to counter decrement input
garrafa_liberada  output  1  one-cycle pulse to conveyor: bottle may leave
erro_sem_rolha  output  1  waiting for corks (LED)
estado  output  3  current state code, for debug/HEX display
total_vedadas  output  14  completed seals, saturating

Behaviour:
- All outputs are registered. Reset values: atuador_vedacao=0, vedacao_concluida=0, garrafa_liberada=0, erro_sem_rolha=0, estado=IDLE(0), total_vedadas=0, timer=0.
- Reset asserted at any time, including mid-seal, returns the block to IDLE immediately with the actuator off and no pulse.
- State codes: IDLE=0, VERIFICA=1, VEDANDO=2, CONCLUI=3, AGUARDA_SAIDA=4, SEM_ROLHA=5. Codes 6 and 7 go to IDLE on the next clock with all pulses low.
- IDLE: if enable && garrafa_posicionada, go to VERIFICA.
- VERIFICA (≥ 1 cycle):
  - if dispensador_ativo, stay in VERIFICA;
  - else if rolha_disponivel, go to VEDANDO and clear the timer;
  - else go to SEM_ROLHA.
- VEDANDO:
  - atuador_vedacao=1 for exactly TEMPO_VEDACAO cycles; the timer increments each cycle.
  - At timer==TEMPO_VEDACAO-1, go to CONCLUI.
  - enable dropping or the sensor dropping does not abort; the seal always completes.
- CONCLUI (exactly 1 cycle):
  - vedacao_concluida=1 and garrafa_liberada=1; actuator off.
  - total_vedadas increments by 1, unless already at MAX_VEDADAS, where it holds.
  - Then go to AGUARDA_SAIDA.
- AGUARDA_SAIDA: wait until garrafa_posicionada==0, then go to IDLE. This blocks double-sealing the same bottle.
- SEM_ROLHA:
  - erro_sem_rolha=1.
  - If garrafa_posicionada==0 (bottle removed by operator), go to IDLE with no pulse.
  - Else if rolha_disponivel && !dispensador_ativo, go to VEDANDO and clear the timer; erro_sem_rolha drops in that same cycle.
  - Sensor removal wins over simultaneous cork arrival.
- vedacao_concluida is never high on two consecutive cycles, and never high unless preceded by exactly TEMPO_VEDACAO actuator cycles.
- Latency with sensor high in IDLE at edge k: VERIFICA after k, VEDANDO after k+1, actuator high for cycles k+2..k+1+TEMPO_VEDACAO, pulse in cycle k+2+TEMPO_VEDACAO.
- enable low only prevents leaving IDLE; it has no effect in any other state.

Test Plan (TEMPO_VEDACAO=4 in sim):
1. Reset low mid-run → all outputs 0, estado=0. Release; enable=1, sensor=1, rolha=1 → atuador high exactly 4 cycles, then vedacao_concluida and garrafa_liberada high 1 cycle together, total_vedadas=1, estado=4 until sensor=0, then estado=0.
2. rolha_disponivel=0 at bottle arrival → estado=5, erro_sem_rolha=1, no actuator. Raise rolha after 10 cycles → erro drops, 4 actuator cycles, one pulse, total +1.
3. dispensador_ativo=1 when bottle arrives → estado holds at 1, actuator 0. Drop refill → sealing proceeds normally.
4. Sensor held high for 50 cycles after the pulse → exactly one vedacao_concluida, total_vedadas +1 only.
5. In SEM_ROLHA, sensor and rolha rise/fall in the same cycle (sensor 0, rolha 1) → IDLE, no pulse. Separately: reset asserted during VEDANDO cycle 2 → actuator 0 immediately, no pulse afterwards.
6. Preload by running 9999 seals (or force with parameter MAX_VEDADAS=3) → total_vedadas saturates at 3 and still pulses per bottle.

Source files
------------

// File: rtl/controle_vedacao.sv
// -----------------------------------------------------------------------------
// controle_vedacao
//
// Sealing-station controller for the bottling line. This is the initiator side
// of the cork-consumption interface: it detects a bottle at the sealer, checks
// cork availability and refill status, drives the sealing actuator for a fixed
// number of cycles, then emits the one-cycle "sealing complete" pulse that the
// cork counter decrements on. It also releases the bottle to the conveyor and
// keeps a saturating count of sealed bottles for display.
//
// Handshake semantics: vedacao_concluida is a one-cycle pulse with no ready
// side. The counter must consume it in the cycle it is high. It is never high
// on two consecutive cycles. It is only ever preceded by exactly TEMPO_VEDACAO
// cycles of atuador_vedacao.
//
// Ports:
//   clk                 in   50 MHz system clock
//   reset               in   asynchronous, active-low reset
//   enable              in   line running; new cycles start only while high
//   garrafa_posicionada in   bottle-at-sealer sensor (level, synchronised)
//   rolha_disponivel    in   counter holds at least one cork
//   dispensador_ativo   in   automatic refill in progress; blocks sealing
//   atuador_vedacao     out  sealing actuator drive
//   vedacao_concluida   out  one-cycle pulse to counter decrement input
//   garrafa_liberada    out  one-cycle pulse to conveyor: bottle may leave
//   erro_sem_rolha      out  waiting for corks (LED)
//   estado              out  current state code (debug / HEX display)
//   total_vedadas       out  completed seals, saturating at MAX_VEDADAS
// -----------------------------------------------------------------------------
module controle_vedacao #(
  parameter logic [25:0] TEMPO_VEDACAO = 26'd25000000,
  parameter logic [13:0] MAX_VEDADAS   = 14'd9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        garrafa_posicionada,
  input  logic        rolha_disponivel,
  input  logic        dispensador_ativo,
  output logic        atuador_vedacao,
  output logic        vedacao_concluida,
  output logic        garrafa_liberada,
  output logic        erro_sem_rolha,
  output logic [2:0]  estado,
  output logic [13:0] total_vedadas
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    VERIFICA      = 3'd1,
    VEDANDO       = 3'd2,
    CONCLUI       = 3'd3,
    AGUARDA_SAIDA = 3'd4,
    SEM_ROLHA     = 3'd5
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [25:0] timer_q;
  logic [25:0] timer_d;
  logic        timer_fim;

  // Last actuator cycle: the timer counts 0..TEMPO_VEDACAO-1 inside VEDANDO.
  assign timer_fim = (timer_q == (TEMPO_VEDACAO - 26'd1));

  // ---------------------------------------------------------------------------
  // Next-state and timer logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = '0;

    case (state_q)
      IDLE: begin
        if (enable && garrafa_posicionada) begin
          state_d = VERIFICA;
        end
      end

      VERIFICA: begin
        // A refill in progress holds the station here; the cork count is not
        // trusted until the dispenser has finished.
        if (dispensador_ativo) begin
          state_d = VERIFICA;
        end else if (rolha_disponivel) begin
          state_d = VEDANDO;
        end else begin
          state_d = SEM_ROLHA;
        end
      end

      VEDANDO: begin
        // Neither enable nor the sensor can abort a seal once started.
        if (timer_fim) begin
          state_d = CONCLUI;
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end

      CONCLUI: begin
        state_d = AGUARDA_SAIDA;
      end

      AGUARDA_SAIDA: begin
        // Wait for the bottle to leave so the same bottle is never resealed.
        if (!garrafa_posicionada) begin
          state_d = IDLE;
        end
      end

      SEM_ROLHA: begin
        // Operator removing the bottle wins over a simultaneous cork arrival.
        if (!garrafa_posicionada) begin
          state_d = IDLE;
        end else if (rolha_disponivel && !dispensador_ativo) begin
          state_d = VEDANDO;
        end
      end

      default: begin
        // Unused codes 6 and 7 recover to IDLE with all pulses low.
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and timer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. Each is decoded from the next state so the registered
  // value lines up exactly with the state the block is in during that cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      atuador_vedacao   <= 1'b0;
      vedacao_concluida <= 1'b0;
      garrafa_liberada  <= 1'b0;
      erro_sem_rolha    <= 1'b0;
      total_vedadas     <= '0;
    end else begin
      atuador_vedacao   <= (state_d == VEDANDO);
      vedacao_concluida <= (state_d == CONCLUI);
      garrafa_liberada  <= (state_d == CONCLUI);
      erro_sem_rolha    <= (state_d == SEM_ROLHA);
      if ((state_d == CONCLUI) && (total_vedadas < MAX_VEDADAS)) begin
        total_vedadas <= total_vedadas + 14'd1;
      end
    end
  end

  assign estado = state_q;

endmodule

// File: tb/tb_controle_vedacao.sv
// -----------------------------------------------------------------------------
// tb_controle_vedacao
//
// Self-checking bench for controle_vedacao. Directed sequences walk the main
// scenarios, then randomized inputs run against a behavioural model that
// tracks the station phase, the remaining actuator cycles and the saturating
// seal count. A scoreboard queue holds the expected total for each completion
// pulse, and run-length checks confirm every pulse follows exactly
// TEMPO_VEDACAO actuator cycles and never repeats on consecutive cycles.
// -----------------------------------------------------------------------------
module tb_controle_vedacao;

  localparam logic [25:0] T_VED = 26'd4;
  localparam logic [13:0] MAXV  = 14'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        garrafa_posicionada;
  logic        rolha_disponivel;
  logic        dispensador_ativo;
  logic        atuador_vedacao;
  logic        vedacao_concluida;
  logic        garrafa_liberada;
  logic        erro_sem_rolha;
  logic [2:0]  estado;
  logic [13:0] total_vedadas;

  always #5 clk = ~clk;

  controle_vedacao #(
    .TEMPO_VEDACAO(T_VED),
    .MAX_VEDADAS  (MAXV)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .garrafa_posicionada(garrafa_posicionada),
    .rolha_disponivel   (rolha_disponivel),
    .dispensador_ativo  (dispensador_ativo),
    .atuador_vedacao    (atuador_vedacao),
    .vedacao_concluida  (vedacao_concluida),
    .garrafa_liberada   (garrafa_liberada),
    .erro_sem_rolha     (erro_sem_rolha),
    .estado             (estado),
    .total_vedadas      (total_vedadas)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase 0 idle, 1 checking, 2 sealing, 3 done pulse,
  // 4 waiting for bottle exit, 5 out of corks.
  // ---------------------------------------------------------------------------
  int          m_phase = 0;
  int          m_left  = 0;
  int          m_total = 0;
  logic [13:0] exp_q[$];
  int          atu_run   = 0;
  logic        prev_conc = 1'b0;

  task automatic model_step();
    if (!reset) begin
      m_phase = 0;
      m_left  = 0;
      m_total = 0;
      exp_q.delete();
      return;
    end
    case (m_phase)
      0: if (enable && garrafa_posicionada) m_phase = 1;
      1: begin
        if (!dispensador_ativo) begin
          if (rolha_disponivel) begin
            m_phase = 2;
            m_left  = int'(T_VED);
          end else begin
            m_phase = 5;
          end
        end
      end
      2: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_phase = 3;
          if (m_total < int'(MAXV)) m_total = m_total + 1;
          exp_q.push_back(14'(m_total));
        end
      end
      3: m_phase = 4;
      4: if (!garrafa_posicionada) m_phase = 0;
      5: begin
        if (!garrafa_posicionada) begin
          m_phase = 0;
        end else if (rolha_disponivel && !dispensador_ativo) begin
          m_phase = 2;
          m_left  = int'(T_VED);
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare();
    check("estado",    32'(estado),            32'(m_phase));
    check("atuador",   32'(atuador_vedacao),   32'(m_phase == 2));
    check("concluida", 32'(vedacao_concluida), 32'(m_phase == 3));
    check("liberada",  32'(garrafa_liberada),  32'(m_phase == 3));
    check("erro",      32'(erro_sem_rolha),    32'(m_phase == 5));
    check("total",     32'(total_vedadas),     32'(m_total));
    if (vedacao_concluida) begin
      check("pulse_gap",    32'(prev_conc), 32'd0);
      check("actuator_run", 32'(atu_run),   32'(T_VED));
      if (exp_q.size() > 0) check("sb_total", 32'(total_vedadas), 32'(exp_q.pop_front()));
      else                  check("unexpected_pulse", 32'(vedacao_concluida), 32'd0);
    end
    prev_conc = vedacao_concluida;
    atu_run   = atuador_vedacao ? atu_run + 1 : 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    model_step();
    compare();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_in(input logic en, input logic g, input logic r, input logic d);
    enable              = en;
    garrafa_posicionada = g;
    rolha_disponivel    = r;
    dispensador_ativo   = d;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    model_step();
    compare();
    run(2);
    reset = 1'b1;
    run(1);

    // Normal seal, then bottle exit.
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    run(10);
    garrafa_posicionada = 1'b0;
    run(2);

    // No corks at arrival, corks arrive later.
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    run(12);
    rolha_disponivel = 1'b1;
    run(8);
    garrafa_posicionada = 1'b0;
    run(2);

    // Refill in progress at arrival.
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    run(6);
    dispensador_ativo = 1'b0;
    run(8);
    garrafa_posicionada = 1'b0;
    run(2);

    // Sensor held long after the pulse: only one seal.
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    run(60);
    garrafa_posicionada = 1'b0;
    run(2);

    // Out of corks, then sensor drops as corks arrive: removal wins.
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    run(4);
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    run(3);

    // Reset during the second actuator cycle.
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    run(3);
    pulse_reset();
    garrafa_posicionada = 1'b0;
    run(8);

    // Saturation of the seal count.
    for (int s = 0; s < 5; s++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0);
      run(9);
      garrafa_posicionada = 1'b0;
      run(2);
    end

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) garrafa_posicionada = ~garrafa_posicionada;
      if ($urandom_range(0, 14) == 0) rolha_disponivel    = ~rolha_disponivel;
      if ($urandom_range(0, 24) == 0) dispensador_ativo   = ~dispensador_ativo;
      if ($urandom_range(0, 29) == 0) enable              = ~enable;
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else tick();
    end

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
